// File: rtl/cordic_fixedpoint_anglenormalize_pipe_if.sv
// Handshake bundle for the CORDIC angle-normalise pipe: input phase stream,
// folded output stream and the accepted-sample counter.
interface cordic_fixedpoint_anglenormalize_pipe_if #(
  parameter int PHASE_W = 24,
  parameter int TAG_W   = 4,
  parameter int CNT_W   = 16
);
  logic               iPhase_valid;
  logic               oPhase_ready;
  logic [PHASE_W-1:0] iPhase_data;
  logic               iMode;
  logic [TAG_W-1:0]   iTag;
  logic               oPhase_valid;
  logic               iPhase_ready;
  logic [PHASE_W-3:0] oPhase_normalize;
  logic [2:0]         oPhase_normalize_info;
  logic [TAG_W-1:0]   oTag;
  logic [CNT_W-1:0]   oSample_count;

  modport slave (
    input  iPhase_valid, iPhase_data, iMode, iTag, iPhase_ready,
    output oPhase_ready, oPhase_valid, oPhase_normalize, oPhase_normalize_info,
           oTag, oSample_count
  );

  modport master (
    output iPhase_valid, iPhase_data, iMode, iTag, iPhase_ready,
    input  oPhase_ready, oPhase_valid, oPhase_normalize, oPhase_normalize_info,
           oTag, oSample_count
  );
endinterface

// File: rtl/cordic_fixedpoint_anglenormalize_pipe.sv
// Two-stage valid/ready pipe that folds a binary angle into the first octant
// (mode 0) or quadrant (mode 1) and reports the sign/swap fix-up bits.
module cordic_fixedpoint_anglenormalize_pipe #(
  parameter int PHASE_W = 24,
  parameter int TAG_W   = 4,
  parameter int CNT_W   = 16
) (
  input logic iClk,
  input logic iReset,
  cordic_fixedpoint_anglenormalize_pipe_if.slave phase_if
);

  localparam logic [PHASE_W-3:0] PI4 = {1'b1, {(PHASE_W-3){1'b0}}};

  function automatic logic [PHASE_W-3:0] fold_residual(
    input logic               mode,
    input logic               o,
    input logic [PHASE_W-4:0] r
  );
    logic [PHASE_W-3:0] r_ext;
    r_ext = {1'b0, r};
    if (mode) begin
      fold_residual = {o, r};
    end else if (o) begin
      // Residual width keeps one extra bit so exactly pi/4 survives the mirror.
      fold_residual = PI4 - r_ext;
    end else begin
      fold_residual = r_ext;
    end
  endfunction

  function automatic logic [2:0] fold_info(
    input logic       mode,
    input logic [1:0] q,
    input logic       o
  );
    logic swap;
    swap      = mode ? q[0] : (q[0] ^ o);
    fold_info = {swap, q[1], q[1] ^ q[0]};
  endfunction

  logic               s1_valid_r;
  logic [1:0]         s1_q_r;
  logic               s1_o_r;
  logic [PHASE_W-4:0] s1_r_r;
  logic               s1_mode_r;
  logic [TAG_W-1:0]   s1_tag_r;

  logic               s2_valid_r;
  logic [PHASE_W-3:0] s2_res_r;
  logic [2:0]         s2_info_r;
  logic [TAG_W-1:0]   s2_tag_r;
  logic [CNT_W-1:0]   cnt_r;

  logic s1_load_s;
  logic s2_load_s;
  logic in_xfer_s;

  // Stage-advance and input-transfer decode.
  always_comb begin
    s2_load_s = ~s2_valid_r | phase_if.iPhase_ready;
    s1_load_s = ~s1_valid_r | s2_load_s;
    in_xfer_s = phase_if.iPhase_valid & s1_load_s;
  end

  assign phase_if.oPhase_ready          = s1_load_s;
  assign phase_if.oPhase_valid          = s2_valid_r;
  assign phase_if.oPhase_normalize      = s2_res_r;
  assign phase_if.oPhase_normalize_info = s2_info_r;
  assign phase_if.oTag                  = s2_tag_r;
  assign phase_if.oSample_count         = cnt_r;

  // Stage 1: capture quadrant, octant half, raw residual, mode and tag.
  always_ff @(posedge iClk) begin
    if (iReset) begin
      s1_valid_r <= 1'b0;
      s1_q_r     <= 2'b00;
      s1_o_r     <= 1'b0;
      s1_r_r     <= '0;
      s1_mode_r  <= 1'b0;
      s1_tag_r   <= '0;
    end else if (s1_load_s) begin
      s1_valid_r <= in_xfer_s;
      if (in_xfer_s) begin
        s1_q_r    <= phase_if.iPhase_data[PHASE_W-1:PHASE_W-2];
        s1_o_r    <= phase_if.iPhase_data[PHASE_W-3];
        s1_r_r    <= phase_if.iPhase_data[PHASE_W-4:0];
        s1_mode_r <= phase_if.iMode;
        s1_tag_r  <= phase_if.iTag;
      end
    end
  end

  // Stage 2: fold and register the outputs; they hold while stalled.
  always_ff @(posedge iClk) begin
    if (iReset) begin
      s2_valid_r <= 1'b0;
      s2_res_r   <= '0;
      s2_info_r  <= 3'b000;
      s2_tag_r   <= '0;
    end else if (s2_load_s) begin
      s2_valid_r <= s1_valid_r;
      if (s1_valid_r) begin
        s2_res_r  <= fold_residual(s1_mode_r, s1_o_r, s1_r_r);
        s2_info_r <= fold_info(s1_mode_r, s1_q_r, s1_o_r);
        s2_tag_r  <= s1_tag_r;
      end
    end
  end

  // Accepted-sample counter, wraps naturally.
  always_ff @(posedge iClk) begin
    if (iReset) begin
      cnt_r <= '0;
    end else if (in_xfer_s) begin
      cnt_r <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

endmodule

// File: tb/tb_cordic_fixedpoint_anglenormalize_pipe.sv
// Scoreboard bench: stimulus pushes hand-computed expectations, a negedge
// monitor pops and compares whenever an output transfer occurs.
module tb_cordic_fixedpoint_anglenormalize_pipe;
  localparam int PW = 24;
  localparam int TW = 4;

  typedef struct {
    logic [PW-3:0] res;
    logic [2:0]    info;
    logic [TW-1:0] tag;
    int            issue_cyc;
    bit            chk_lat;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   passes = 0;
  int   xfers = 0;
  bit   saw_bp = 1'b0;
  exp_t sb[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  cordic_fixedpoint_anglenormalize_pipe_if #(.PHASE_W(PW), .TAG_W(TW), .CNT_W(16)) bus ();
  cordic_fixedpoint_anglenormalize_pipe_if #(.PHASE_W(PW), .TAG_W(TW), .CNT_W(4))  bus4 ();

  cordic_fixedpoint_anglenormalize_pipe #(.PHASE_W(PW), .TAG_W(TW), .CNT_W(16)) dut (
    .iClk(clk), .iReset(rst), .phase_if(bus.slave));
  cordic_fixedpoint_anglenormalize_pipe #(.PHASE_W(PW), .TAG_W(TW), .CNT_W(4)) dut4 (
    .iClk(clk), .iReset(rst), .phase_if(bus4.slave));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    checks++;
    if (act === exp_v) passes++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", name, act, exp_v, cyc);
  endtask

  // Called at posedge+1; returns at posedge+1 after the transfer edge.
  task automatic send(input logic [PW-1:0] d, input logic m, input logic [TW-1:0] t,
                      input logic [PW-3:0] er, input logic [2:0] ei, input bit lat);
    int waitc;
    exp_t e;
    waitc = 0;
    bus.iPhase_valid = 1'b1;
    bus.iPhase_data  = d;
    bus.iMode        = m;
    bus.iTag         = t;
    @(negedge clk);
    while (!bus.oPhase_ready && waitc < 50) begin
      saw_bp = 1'b1;
      waitc++;
      @(negedge clk);
    end
    if (!bus.oPhase_ready) begin
      chk("send_timeout", 32'd0, 32'd1);
    end else begin
      e.res = er; e.info = ei; e.tag = t; e.issue_cyc = cyc; e.chk_lat = lat;
      sb.push_back(e);
      xfers++;
    end
    @(posedge clk); #1;
    bus.iPhase_valid = 1'b0;
    bus.iPhase_data  = '1;
    bus.iMode        = ~m;
  endtask

  // Output monitor: scoreboard compare plus stall-hold stability.
  always @(negedge clk) begin : mon
    exp_t e;
    logic          hold_pending;
    logic [PW-3:0] h_res;
    logic [2:0]    h_info;
    logic [TW-1:0] h_tag;
    if (rst) hold_pending = 1'b0;
    if (bus.oPhase_valid && hold_pending === 1'b1) begin
      chk("hold_res", 32'(bus.oPhase_normalize), 32'(h_res));
      chk("hold_info", 32'(bus.oPhase_normalize_info), 32'(h_info));
      chk("hold_tag", 32'(bus.oTag), 32'(h_tag));
    end
    if (bus.oPhase_valid && bus.iPhase_ready) begin
      if (sb.size() == 0) begin
        chk("unexpected_output", 32'(bus.oTag), 32'hFFFF_FFFF);
      end else begin
        e = sb.pop_front();
        chk("residual", 32'(bus.oPhase_normalize), 32'(e.res));
        chk("info", 32'(bus.oPhase_normalize_info), 32'(e.info));
        chk("tag", 32'(bus.oTag), 32'(e.tag));
        if (e.chk_lat) chk("latency", 32'(cyc - e.issue_cyc), 32'd2);
      end
    end
    hold_pending = bus.oPhase_valid & ~bus.iPhase_ready;
    h_res  = bus.oPhase_normalize;
    h_info = bus.oPhase_normalize_info;
    h_tag  = bus.oTag;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n4;
    bus.iPhase_valid = 1'b0; bus.iPhase_data = '0; bus.iMode = 1'b0;
    bus.iTag = '0; bus.iPhase_ready = 1'b1;
    bus4.iPhase_valid = 1'b0; bus4.iPhase_data = '0; bus4.iMode = 1'b0;
    bus4.iTag = '0; bus4.iPhase_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_valid", 32'(bus.oPhase_valid), 32'd0);
    chk("rst_count", 32'(bus.oSample_count), 32'd0);
    chk("rst_res", 32'(bus.oPhase_normalize), 32'd0);
    chk("rst_info", 32'(bus.oPhase_normalize_info), 32'd0);
    chk("rst_tag", 32'(bus.oTag), 32'd0);
    chk("rst_ready", 32'(bus.oPhase_ready), 32'd1);
    @(posedge clk); #1;

    // Directed vectors, back-to-back, alternating mode.
    send(24'h300000, 1'b0, 4'd1, 22'h100000, 3'b100, 1'b1);
    send(24'h600000, 1'b0, 4'd2, 22'h200000, 3'b001, 1'b1);
    send(24'hC00000, 1'b0, 4'd3, 22'h000000, 3'b110, 1'b1);
    send(24'hC00000, 1'b1, 4'd4, 22'h000000, 3'b110, 1'b1);
    send(24'h5FFFFF, 1'b1, 4'd5, 22'h1FFFFF, 3'b101, 1'b1);
    send(24'h1FFFFF, 1'b0, 4'd6, 22'h1FFFFF, 3'b000, 1'b1);
    send(24'hA00001, 1'b0, 4'd7, 22'h1FFFFF, 3'b111, 1'b1);
    send(24'hA00001, 1'b1, 4'd8, 22'h200001, 3'b011, 1'b1);
    repeat (4) @(posedge clk); #1;
    chk("drain_directed", 32'(sb.size()), 32'd0);

    // Stream of tags 0..7 with downstream stall on cycles 3..5.
    fork
      begin
        for (int t = 0; t < 8; t++)
          send(PW'(t), 1'b0, TW'(t), (PW-2)'(t), 3'b000, 1'b0);
      end
      begin
        repeat (3) @(posedge clk); #1 bus.iPhase_ready = 1'b0;
        repeat (3) @(posedge clk); #1 bus.iPhase_ready = 1'b1;
      end
    join
    repeat (5) @(posedge clk); #1;
    chk("stream_backpressure", 32'(saw_bp), 32'd1);
    chk("drain_stream", 32'(sb.size()), 32'd0);
    @(negedge clk);
    chk("count_main", 32'(bus.oSample_count), 32'(xfers));
    @(posedge clk); #1;

    // Reset with two samples in flight.
    bus.iPhase_ready = 1'b0;
    send(24'h300000, 1'b0, 4'hA, 22'h100000, 3'b100, 1'b0);
    send(24'h600000, 1'b0, 4'hB, 22'h200000, 3'b001, 1'b0);
    rst = 1'b1;
    sb.delete();
    xfers = 0;
    @(posedge clk); #1;
    rst = 1'b0;
    bus.iPhase_ready = 1'b1;
    @(negedge clk);
    chk("midrst_valid", 32'(bus.oPhase_valid), 32'd0);
    chk("midrst_count", 32'(bus.oSample_count), 32'd0);
    chk("midrst_ready", 32'(bus.oPhase_ready), 32'd1);
    @(posedge clk); #1;
    send(24'hC00000, 1'b1, 4'hC, 22'h000000, 3'b110, 1'b1);
    repeat (4) @(posedge clk); #1;
    chk("drain_after_reset", 32'(sb.size()), 32'd0);
    @(negedge clk);
    chk("count_after_reset", 32'(bus.oSample_count), 32'(xfers));

    // Narrow counter wraps: 17 transfers on a 4-bit counter.
    @(posedge clk); #1;
    n4 = 0;
    bus4.iPhase_valid = 1'b1;
    for (int i = 0; i < 17; i++) begin
      bus4.iTag = TW'(i);
      @(negedge clk);
      if (bus4.oPhase_ready) n4++;
      @(posedge clk); #1;
    end
    bus4.iPhase_valid = 1'b0;
    @(negedge clk);
    chk("cnt4_xfers", 32'(n4), 32'd17);
    chk("cnt4_wrap", 32'(bus4.oSample_count), 32'd1);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule

// File: doc/cordic_fixedpoint_anglenormalize_pipe.md
CORDIC_FIXEDPOINT_ANGLENORMALIZE_PIPE -- requirements
Module: cordic_fixedpoint_anglenormalize_pipe

Interface
REQ-001 Parameters SHALL be, one per line as name, default, meaning:
- PHASE_W, 24, input phase width (binary angle, full circle = 2^PHASE_W); legal range 8..32.
- TAG_W, 4, width of the sideband tag carried alongside each sample.
- CNT_W, 16, width of the accepted-sample counter.
REQ-002 Ports SHALL be, one per line as name, direction, width, meaning:
- iClk  in  1  single clock; all logic is on its rising edge.
- iReset  in  1  reset; synchronous, active-high.
- iPhase_valid  in  1  input sample valid.
- oPhase_ready  out  1  block can accept an input sample.
- iPhase_data  in  PHASE_W  unsigned binary angle.
- iMode  in  1  0 = octant fold to [0, pi/4]; 1 = quadrant fold to [0, pi/2).
- iTag  in  TAG_W  sideband tag, returned unchanged.
- oPhase_valid  out  1  output sample valid.
- iPhase_ready  in  1  downstream accepts the output sample.
- oPhase_normalize  out  PHASE_W-2  folded residual angle.
- oPhase_normalize_info  out  3  {swap, neg_sin, neg_cos}.
- oTag  out  TAG_W  tag of the output sample.
- oSample_count  out  CNT_W  count of accepted input samples.

Function
REQ-003 Input notation: q = iPhase_data[PHASE_W-1:PHASE_W-2] (quadrant); o = iPhase_data[PHASE_W-3] (octant half).
REQ-004 In mode 0, r = iPhase_data[PHASE_W-4:0], and the residual SHALL be r if o=0, else 2^(PHASE_W-3) - r, zero-extended to PHASE_W-2 bits; exactly pi/4 (2^(PHASE_W-3)) SHALL be representable.
REQ-005 In mode 1, the residual SHALL be iPhase_data[PHASE_W-3:0], with no mirroring.
REQ-006 swap SHALL be q[0] XOR o in mode 0 and q[0] in mode 1; neg_sin SHALL be q[1]; neg_cos SHALL be q[1] XOR q[0].
REQ-007 An input transfer SHALL occur on a cycle where iPhase_valid and oPhase_ready are both 1; an output transfer SHALL occur where oPhase_valid and iPhase_ready are both 1.
REQ-008 The datapath SHALL be a two-stage pipeline:
- S1 registers q, o, the raw residual bits, iMode and iTag.
- S2 registers the folded residual, info and tag.
REQ-009 Latency SHALL be exactly 2 cycles from input transfer to oPhase_valid when iPhase_ready is held 1; sustained throughput SHALL be 1 sample per cycle.
REQ-010 Each stage SHALL load when its valid is 0 or the downstream stage advances; oPhase_ready SHALL be ~s1_valid OR (~s2_valid OR iPhase_ready), combinational.
REQ-011 While oPhase_valid=1 and iPhase_ready=0, oPhase_normalize, info and oTag SHALL hold stable; no sample SHALL be dropped or duplicated.
REQ-012 With both stages full and iPhase_ready=0, oPhase_ready SHALL be 0; with a simultaneous input and output transfer, both stages SHALL advance in the same cycle.
REQ-013 iMode SHALL be sampled per transfer; a mode change between consecutive samples SHALL affect only samples accepted after the change.
REQ-014 oSample_count SHALL increment by 1 per input transfer and wrap from 2^CNT_W-1 to 0.
REQ-015 Inputs on cycles without an input transfer SHALL have no effect on the pipeline.

Reset
REQ-016 While iReset=1 at a clock edge, both stage valids, oPhase_valid, oPhase_normalize, oPhase_normalize_info, oTag and oSample_count SHALL become 0.
REQ-017 Reset asserted mid-operation SHALL discard in-flight samples; the first input transfer after reset deasserts SHALL emerge 2 cycles later.
REQ-018 oPhase_ready SHALL be 1 on the first cycle after reset deasserts.

Verification (PHASE_W=24)
REQ-019 Mode 0, 0x300000 -> residual 0x100000, info 3'b100, after 2 cycles.
REQ-020 Mode 0, 0x600000 -> residual 0x200000, info 3'b001; mode 0, 0xC00000 -> residual 0x000000, info 3'b110.
REQ-021 Mode 1, 0xC00000 -> residual 0x000000, info 3'b110; mode 1, 0x5FFFFF -> residual 0x1FFFFF, info 3'b101.
REQ-022 Back-to-back stream of tags 0..7 with iPhase_ready low for cycles 3..5 -> oPhase_ready low after both stages fill; outputs stall stable; tags emerge 0..7 in order, none lost.
REQ-023 Reset pulse while 2 samples are in flight -> oPhase_valid 0 and oSample_count 0 the next cycle; a new sample emerges 2 cycles after its input transfer.
REQ-024 CNT_W=4, 17 input transfers -> oSample_count = 1.
